// File: rtl/swicth_net_seq_2_1.sv
// Barrel-threaded switch sequencer.
// Holds per-thread configuration words plus pc_max/pc_loop, visits one thread
// per cycle round-robin, and registers the fetched word as the switch mux select.
module swicth_net_seq_2_1 #(
    parameter int THREADS = 8,
    parameter int PC_W    = 1,
    parameter int DATA_W  = 2,
    localparam int TID_W  = $clog2(THREADS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    input  logic [TID_W-1:0]  thread_id,
    input  logic [PC_W-1:0]   pc_max,
    input  logic              pc_max_we,
    input  logic [PC_W-1:0]   pc_loop,
    input  logic              pc_loop_we,
    input  logic              net_mem_we,
    input  logic [PC_W-1:0]   net_mem_waddr,
    input  logic [DATA_W-1:0] net_mem_data,
    output logic [DATA_W-1:0] sel,
    output logic              sel_valid,
    output logic [TID_W-1:0]  sel_thread,
    output logic [PC_W-1:0]   sel_pc
);

    localparam int WORDS = 1 << PC_W;
    localparam int MEM_N = THREADS * WORDS;

    logic [DATA_W-1:0] mem_q    [MEM_N];
    logic [DATA_W-1:0] mem_d    [MEM_N];
    logic [PC_W-1:0]   pcmax_q  [THREADS];
    logic [PC_W-1:0]   pcmax_d  [THREADS];
    logic [PC_W-1:0]   pcloop_q [THREADS];
    logic [PC_W-1:0]   pcloop_d [THREADS];
    logic [PC_W-1:0]   pc_q     [THREADS];
    logic [PC_W-1:0]   pc_d     [THREADS];
    logic [TID_W-1:0]  tp_q, tp_d;
    logic [DATA_W-1:0] sel_q, sel_d;
    logic              sel_valid_q, sel_valid_d;
    logic [TID_W-1:0]  sel_thread_q, sel_thread_d;
    logic [PC_W-1:0]   sel_pc_q, sel_pc_d;

    // PC of the thread currently being visited.
    logic [PC_W-1:0] pc_cur;
    assign pc_cur = pc_q[tp_q];

    // Configuration writes; the sequencer reads the _q copies, so a write that
    // collides with a fetch or advance only takes effect on the next visit.
    always_comb begin
        mem_d    = mem_q;
        pcmax_d  = pcmax_q;
        pcloop_d = pcloop_q;
        if (net_mem_we) begin
            mem_d[{thread_id, net_mem_waddr}] = net_mem_data;
        end
        if (pc_max_we) begin
            pcmax_d[thread_id] = pc_max;
        end
        if (pc_loop_we) begin
            pcloop_d[thread_id] = pc_loop;
        end
    end

    // Fetch and advance the visited thread; idle clears all PCs and the pointer.
    always_comb begin
        pc_d         = pc_q;
        tp_d         = tp_q;
        sel_d        = sel_q;
        sel_thread_d = sel_thread_q;
        sel_pc_d     = sel_pc_q;
        sel_valid_d  = 1'b0;
        if (run) begin
            sel_d        = mem_q[{tp_q, pc_cur}];
            sel_thread_d = tp_q;
            sel_pc_d     = pc_cur;
            sel_valid_d  = 1'b1;
            pc_d[tp_q]   = (pc_cur == pcmax_q[tp_q]) ? pcloop_q[tp_q]
                                                     : pc_cur + PC_W'(1);
            tp_d         = tp_q + TID_W'(1);
        end else begin
            for (int i = 0; i < THREADS; i++) begin
                pc_d[i] = '0;
            end
            tp_d = '0;
        end
    end

    // State registers; reset also wipes the loaded program.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q        <= '{default: '0};
            pcmax_q      <= '{default: '0};
            pcloop_q     <= '{default: '0};
            pc_q         <= '{default: '0};
            tp_q         <= '0;
            sel_q        <= '0;
            sel_valid_q  <= 1'b0;
            sel_thread_q <= '0;
            sel_pc_q     <= '0;
        end else begin
            mem_q        <= mem_d;
            pcmax_q      <= pcmax_d;
            pcloop_q     <= pcloop_d;
            pc_q         <= pc_d;
            tp_q         <= tp_d;
            sel_q        <= sel_d;
            sel_valid_q  <= sel_valid_d;
            sel_thread_q <= sel_thread_d;
            sel_pc_q     <= sel_pc_d;
        end
    end

    assign sel        = sel_q;
    assign sel_valid  = sel_valid_q;
    assign sel_thread = sel_thread_q;
    assign sel_pc     = sel_pc_q;

endmodule

// File: tb/tb_swicth_net_seq_2_1.sv
// Bench for swicth_net_seq_2_1: directed scenarios plus random traffic,
// every cycle checked against a behavioural model of threads and programs.
module tb_swicth_net_seq_2_1;

    localparam int THREADS = 8;
    localparam int PC_W    = 1;
    localparam int DATA_W  = 2;
    localparam int TID_W   = 3;
    localparam int WORDS   = 1 << PC_W;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              run = 1'b0;
    logic [TID_W-1:0]  thread_id = '0;
    logic [PC_W-1:0]   pc_max = '0;
    logic              pc_max_we = 1'b0;
    logic [PC_W-1:0]   pc_loop = '0;
    logic              pc_loop_we = 1'b0;
    logic              net_mem_we = 1'b0;
    logic [PC_W-1:0]   net_mem_waddr = '0;
    logic [DATA_W-1:0] net_mem_data = '0;
    logic [DATA_W-1:0] sel;
    logic              sel_valid;
    logic [TID_W-1:0]  sel_thread;
    logic [PC_W-1:0]   sel_pc;

    swicth_net_seq_2_1 #(.THREADS(THREADS), .PC_W(PC_W), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst_n(rst_n), .run(run), .thread_id(thread_id),
        .pc_max(pc_max), .pc_max_we(pc_max_we), .pc_loop(pc_loop), .pc_loop_we(pc_loop_we),
        .net_mem_we(net_mem_we), .net_mem_waddr(net_mem_waddr), .net_mem_data(net_mem_data),
        .sel(sel), .sel_valid(sel_valid), .sel_thread(sel_thread), .sel_pc(sel_pc)
    );

    always #5 clk = ~clk;

    // Reference model: plain integers per thread.
    int m_mem [THREADS][WORDS];
    int m_pmax [THREADS];
    int m_ploop [THREADS];
    int m_pc [THREADS];
    int m_tp;
    int e_sel, e_valid, e_thr, e_pc;
    int n_cmp = 0;
    int n_mis = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic check_all();
        check("sel_valid", {31'd0, sel_valid}, e_valid);
        check("sel", {30'd0, sel}, e_sel);
        check("sel_thread", {29'd0, sel_thread}, e_thr);
        check("sel_pc", {31'd0, sel_pc}, e_pc);
    endtask

    task automatic model_reset();
        for (int t = 0; t < THREADS; t++) begin
            for (int w = 0; w < WORDS; w++) m_mem[t][w] = 0;
            m_pmax[t] = 0; m_ploop[t] = 0; m_pc[t] = 0;
        end
        m_tp = 0; e_sel = 0; e_valid = 0; e_thr = 0; e_pc = 0;
    endtask

    task automatic cycle();
        int cur;
        @(posedge clk);
        if (rst_n) begin
            if (run) begin
                cur     = m_pc[m_tp];
                e_sel   = m_mem[m_tp][cur];
                e_thr   = m_tp;
                e_pc    = cur;
                e_valid = 1;
                m_pc[m_tp] = (cur == m_pmax[m_tp]) ? m_ploop[m_tp] : (cur + 1) % WORDS;
                m_tp = (m_tp + 1) % THREADS;
            end else begin
                for (int t = 0; t < THREADS; t++) m_pc[t] = 0;
                m_tp = 0;
                e_valid = 0;
            end
            if (net_mem_we) m_mem[int'(thread_id)][int'(net_mem_waddr)] = int'(net_mem_data);
            if (pc_max_we)  m_pmax[int'(thread_id)]  = int'(pc_max);
            if (pc_loop_we) m_ploop[int'(thread_id)] = int'(pc_loop);
        end
        #1 check_all();
    endtask

    task automatic wr(input int tid, input bit mx_we, input int mx, input bit lp_we, input int lp,
                      input bit m_we, input int addr, input int data);
        thread_id = TID_W'(tid);
        pc_max_we = mx_we; pc_max = PC_W'(mx);
        pc_loop_we = lp_we; pc_loop = PC_W'(lp);
        net_mem_we = m_we; net_mem_waddr = PC_W'(addr); net_mem_data = DATA_W'(data);
        cycle();
        pc_max_we = 1'b0; pc_loop_we = 1'b0; net_mem_we = 1'b0;
    endtask

    initial begin
        model_reset();

        // Reset held with run high and strobes toggling: outputs stay cleared.
        run = 1'b1;
        for (int i = 0; i < 4; i++) begin
            thread_id = TID_W'($urandom); net_mem_waddr = PC_W'($urandom);
            net_mem_data = DATA_W'($urandom); pc_max = PC_W'($urandom); pc_loop = PC_W'($urandom);
            net_mem_we = 1'b1; pc_max_we = 1'b1; pc_loop_we = 1'b1;
            cycle();
        end
        net_mem_we = 1'b0; pc_max_we = 1'b0; pc_loop_we = 1'b0;
        rst_n = 1'b1;

        // First edge after release with run high.
        cycle();
        check("rel_thread", {29'd0, sel_thread}, 0);
        check("rel_valid", {31'd0, sel_valid}, 1);

        // Load programs while idle.
        run = 1'b0;
        wr(3, 1, 1, 1, 0, 1, 0, 1);
        wr(3, 0, 0, 0, 0, 1, 1, 2);
        wr(5, 1, 1, 1, 1, 0, 0, 0);
        wr(4, 1, 1, 1, 0, 0, 0, 0);

        run = 1'b1;
        repeat (40) cycle();

        // Memory write colliding with fetch of thread 2, pc 0.
        for (int i = 0; i < 64 && m_tp != 2; i++) cycle();
        check("wait_tp2", m_tp, 2);
        wr(2, 0, 0, 0, 0, 1, 0, 3);
        check("coll_old_sel", {30'd0, sel}, 0);
        repeat (8) cycle();
        check("coll_new_thr", {29'd0, sel_thread}, 2);
        check("coll_new_sel", {30'd0, sel}, 3);

        // pc_max write colliding with thread 4's advance at pc 0.
        for (int i = 0; i < 64 && !(m_tp == 4 && m_pc[4] == 0); i++) cycle();
        check("wait_tp4", m_tp * 10 + m_pc[4], 40);
        wr(4, 1, 0, 0, 0, 0, 0, 0);
        check("pmx_pc0", {31'd0, sel_pc}, 0);
        repeat (8) cycle();
        check("pmx_thr", {29'd0, sel_thread}, 4);
        check("pmx_pc1", {31'd0, sel_pc}, 1);
        repeat (8) cycle();
        check("pmx_wrap", {31'd0, sel_pc}, 0);

        // run toggle mid-program.
        repeat (3) cycle();
        run = 1'b0;
        repeat (3) cycle();
        run = 1'b1;
        cycle();
        check("restart_thr", {29'd0, sel_thread}, 0);
        check("restart_pc", {31'd0, sel_pc}, 0);
        repeat (16) cycle();

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            run = ($urandom_range(0, 9) != 0);
            thread_id = TID_W'($urandom);
            pc_max = PC_W'($urandom); pc_loop = PC_W'($urandom);
            net_mem_waddr = PC_W'($urandom); net_mem_data = DATA_W'($urandom);
            pc_max_we = ($urandom_range(0, 3) == 0);
            pc_loop_we = ($urandom_range(0, 3) == 0);
            net_mem_we = ($urandom_range(0, 2) == 0);
            cycle();
        end
        pc_max_we = 1'b0; pc_loop_we = 1'b0; net_mem_we = 1'b0;
        run = 1'b1;
        repeat (4) cycle();

        // Asynchronous reset mid-operation clears outputs without a clock edge.
        #2 rst_n = 1'b0;
        #1 model_reset();
        check_all();
        cycle();
        rst_n = 1'b1;
        repeat (16) cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
